spi_slave_fifo: RTL

- Parametrised successor to the single-byte SPI slave echo driver.
- Mode-0 SPI slave, WIDTH-bit words, MSB first.
- Received words go into an RX FIFO; transmitted words come from a TX FIFO, each DEPTH deep.
- Adds sticky overflow/underrun status and an LED view of the last received word. Sits between the external SPI master pins and fabric logic in the clk_25mhz domain.

---
 rtl/spi_slave_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: mode-0 SPI slave, WIDTH-bit MSB-first words, RX/TX FIFOs, sticky status, LED view.
// Define SPI_SLAVE_ECHO_EN to echo the last received word instead of FILL on TX underrun.
module spi_slave_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter logic [WIDTH-1:0] FILL = '0
) (
  input  logic                         clk_25mhz,
  input  logic                         resetn,
  input  logic                         sck,
  input  logic                         mosi,
  input  logic                         ssel,
  output logic                         miso,
  output logic [WIDTH-1:0]             rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  input  logic [WIDTH-1:0]             tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [$clog2(DEPTH+1)-1:0]   rx_count,
  output logic [$clog2(DEPTH+1)-1:0]   tx_count,
  output logic                         overflow,
  output logic                         underrun,
  input  logic                         clear_flags,
  output logic [7:0]                   led
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q;
  logic [2:0]       sck_q, ssel_q, mosi_q;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] rx_sh_q, tx_sh_q, tx_sh_d, last_q;
  logic             skip_q, overflow_q, underrun_q, ovf_d, und_d;
  logic [WIDTH-1:0] rx_mem_q [DEPTH];
  logic [WIDTH-1:0] tx_mem_q [DEPTH];
  logic [AW-1:0]    rx_rd_q, rx_wr_q, tx_rd_q, tx_wr_q;
  logic [CW-1:0]    rx_cnt_q, tx_cnt_q, rx_cnt_d, tx_cnt_d;
  logic             sck_rise, sck_fall, ssel_rise, ssel_fall, active;
  logic             bit_en, shift_en, word_done, load, tx_empty;
  logic             tx_pop, tx_push, rx_pop, rx_push;
  logic [WIDTH-1:0] rx_word, fill_word;

  assign active   = state_q == ACTIVE;
  assign miso     = active & tx_sh_q[WIDTH-1];
  assign rx_valid = rx_cnt_q != '0;
  assign rx_data  = rx_valid ? rx_mem_q[rx_rd_q] : '0;
  assign tx_ready = tx_cnt_q != CW'(DEPTH);
  assign rx_count = rx_cnt_q;
  assign tx_count = tx_cnt_q;
  assign overflow = overflow_q;
  assign underrun = underrun_q;
  assign rx_word  = {rx_sh_q[WIDTH-2:0], mosi_q[2]};

`ifdef SPI_SLAVE_ECHO_EN
  assign fill_word = word_done ? rx_word : last_q;
`else
  assign fill_word = FILL;
`endif

  if (WIDTH >= 8) begin : g_led
    assign led = last_q[7:0];
  end else begin : g_led
    assign led = {{(8-WIDTH){1'b0}}, last_q};
  end

  always_comb begin
    sck_rise  = sck_q[1] & ~sck_q[2];
    sck_fall  = ~sck_q[1] & sck_q[2];
    ssel_rise = ssel_q[1] & ~ssel_q[2];
    ssel_fall = ~ssel_q[1] & ssel_q[2];
    bit_en    = active & ~ssel_rise & sck_rise;
    shift_en  = active & ~ssel_rise & sck_fall & ~skip_q;
    word_done = bit_en & (bit_q == BW'(WIDTH-1));
    load      = ssel_fall | word_done;
    tx_empty  = tx_cnt_q == '0;
    tx_pop    = load & ~tx_empty;
    tx_push   = tx_valid & tx_ready;
    rx_pop    = rx_valid & rx_ready;
    rx_push   = word_done & ((rx_cnt_q != CW'(DEPTH)) | rx_pop);
    tx_sh_d   = load ? (tx_empty ? fill_word : tx_mem_q[tx_rd_q]) :
                shift_en ? {tx_sh_q[WIDTH-2:0], 1'b0} : tx_sh_q;
    bit_d     = (ssel_fall | ssel_rise | word_done) ? '0 : bit_en ? bit_q + BW'(1) : bit_q;
    rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    // a set event in the same cycle as clear_flags wins
    ovf_d     = (overflow_q & ~clear_flags) | (word_done & ~rx_push);
    und_d     = (underrun_q & ~clear_flags) | (load & tx_empty);
  end

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sck_q      <= '0;
      ssel_q     <= '1;
      mosi_q     <= '0;
      bit_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      last_q     <= '0;
      skip_q     <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      rx_rd_q    <= '0;
      rx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_wr_q    <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      sck_q      <= {sck_q[1:0], sck};
      ssel_q     <= {ssel_q[1:0], ssel};
      mosi_q     <= {mosi_q[1:0], mosi};
      state_q    <= ssel_fall ? ACTIVE : ssel_rise ? IDLE : state_q;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      overflow_q <= ovf_d;
      underrun_q <= und_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      if (bit_en) rx_sh_q <= rx_word;
      if (word_done) last_q <= rx_word;
      // the falling edge right after a word's last bit must keep the freshly loaded MSB
      skip_q     <= word_done ? 1'b1 : (sck_fall | ssel_fall) ? 1'b0 : skip_q;
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop) tx_rd_q <= tx_rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_word;
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
  end
endmodule
